// File: rtl/serial_deserializer.sv
// MSB-first serial-to-parallel converter feeding a priority encoder.
// A partial word is dropped (gap_err_o pulse) if data_val_i stays low for GAP_TIMEOUT cycles.
module serial_deserializer #(
  parameter int WIDTH       = 7,
  parameter int GAP_TIMEOUT = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             data_i,
  input  logic             data_val_i,
  output logic [WIDTH-1:0] deser_data_o,
  output logic             deser_data_val_o,
  output logic             busy_o,
  output logic             gap_err_o
);
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int GW    = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
  localparam int GT_M1 = (GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, ASSEMBLE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             val_q, val_d;
  logic             err_q, err_d;

  logic             last_bit;
  logic             timeout;
  logic [WIDTH-1:0] shifted;

  assign shifted  = (shift_q << 1) | WIDTH'(data_i);
  assign last_bit = data_val_i && (cnt_q == CW'(WIDTH - 1));
  // An accepted bit on the timeout cycle wins over the timeout.
  assign timeout  = (GAP_TIMEOUT > 0) && (state_q == ASSEMBLE) && !data_val_i &&
                    (gap_q == GW'(GT_M1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (data_val_i && !last_bit) state_d = ASSEMBLE;
      ASSEMBLE: if (last_bit || timeout)     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    data_d  = data_q;
    val_d   = 1'b0;
    err_d   = 1'b0;
    if (data_val_i) begin
      gap_d   = '0;
      shift_d = shifted;
      if (last_bit) begin
        cnt_d  = '0;
        data_d = shifted;
        val_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (timeout) begin
      cnt_d = '0;
      gap_d = '0;
      err_d = 1'b1;
    end else if (state_q == ASSEMBLE) begin
      gap_d = gap_q + GW'(1);
    end
  end

  always_comb begin
    busy_o           = (state_q == ASSEMBLE);
    deser_data_o     = data_q;
    deser_data_val_o = val_q;
    gap_err_o        = err_q;
  end
endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer at WIDTH=7, GAP_TIMEOUT=8.
module tb_serial_deserializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       dval = 1'b0;
  logic [6:0] dout;
  logic       dout_val, busy, gap_err;
  int         checks = 0;
  int         errs = 0;

  serial_deserializer #(.WIDTH(7), .GAP_TIMEOUT(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(din), .data_val_i(dval),
    .deser_data_o(dout), .deser_data_val_o(dout_val), .busy_o(busy), .gap_err_o(gap_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of input, then observe 1 time unit after the edge.
  task automatic step(input logic v, input logic b);
    dval = v;
    din  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [6:0] w);
    for (int i = 6; i >= 0; i--) step(1'b1, w[i]);
  endtask

  initial begin
    int pulses;
    logic err_seen;
    logic [6:0] w;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", dout, 0);
    chk("rst_val", dout_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", gap_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word 1011001
    step(1'b1, 1'b1);
    chk("w1_busy_first", busy, 1);
    w = 7'b1011001;
    for (int i = 5; i >= 0; i--) step(1'b1, w[i]);
    chk("w1_val", dout_val, 1);
    chk("w1_data", dout, 7'h59);
    chk("w1_busy_done", busy, 0);
    step(1'b0, 1'b0);
    chk("w1_val_1cyc", dout_val, 0);
    chk("w1_hold", dout, 7'h59);
    chk("w1_idle_err", gap_err, 0);

    // Back-to-back 7F then 01, pulses exactly 7 cycles apart
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, (i < 7) || (i == 13));
      if (dout_val) pulses++;
      if (i == 6) begin
        chk("b2b_val0", dout_val, 1);
        chk("b2b_data0", dout, 7'h7F);
      end
      if (i == 7) chk("b2b_busy_nobubble", busy, 1);
      if (i == 12) chk("b2b_no_early", dout_val, 0);
    end
    chk("b2b_val1", dout_val, 1);
    chk("b2b_data1", dout, 7'h01);
    step(1'b0, 1'b0);
    chk("b2b_pulses", pulses, 2);

    // Word 0000001 with a 7-cycle gap after bit 3: no timeout
    err_seen = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    repeat (7) begin
      step(1'b0, 1'b1);
      err_seen |= gap_err;
    end
    chk("gap7_busy", busy, 1);
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    err_seen |= gap_err;
    chk("gap7_err", err_seen, 0);
    chk("gap7_val", dout_val, 1);
    chk("gap7_data", dout, 7'h01);

    // 3 bits then an 8-cycle gap: timeout
    repeat (3) step(1'b1, 1'b1);
    repeat (7) step(1'b0, 1'b0);
    chk("to_busy_before", busy, 1);
    chk("to_err_before", gap_err, 0);
    step(1'b0, 1'b0);
    chk("to_err", gap_err, 1);
    chk("to_busy", busy, 0);
    chk("to_val", dout_val, 0);
    chk("to_data_kept", dout, 7'h01);
    step(1'b0, 1'b0);
    chk("to_err_1cyc", gap_err, 0);
    send_word(7'b0101010);
    chk("to_next_val", dout_val, 1);
    chk("to_next_data", dout, 7'h2A);

    // Asynchronous reset mid-word
    repeat (4) step(1'b1, 1'b1);
    dval = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data", dout, 0);
    chk("arst_val", dout_val, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", gap_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(7'b1110000);
    chk("arst_next_val", dout_val, 1);
    chk("arst_next_data", dout, 7'h70);

    // Valid bit lands exactly on the 8th gap cycle
    err_seen = 1'b0;
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    repeat (7) begin
      step(1'b0, 1'b0);
      err_seen |= gap_err;
    end
    step(1'b1, 1'b1);
    err_seen |= gap_err;
    chk("edge_busy", busy, 1);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b1);
    chk("edge_val", dout_val, 1);
    chk("edge_data", dout, 7'h59);
    step(1'b0, 1'b0);
    err_seen |= gap_err;
    chk("edge_err", err_seen, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #20000;
    errs++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
